// File: rtl/tff_ctrl_pkg.sv
// Shared types, defaults and small arithmetic helpers for the tff bank sequencer.
package tff_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_READ_MEAS,
    ST_GAP,
    ST_RESP
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int unsigned MAX_COUNT_DEF = 59;
  localparam int unsigned TIMEOUT_DEF   = 127;
  localparam int unsigned GAP_DEF       = 2;

  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned lim);
    int unsigned s;
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

  function automatic int unsigned floor_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : 0;
  endfunction

endpackage

// File: rtl/tff_pulse_timer.sv
// Shared timing resource: loadable down-counter for pulse/gap length and a
// saturating up-counter with watchdog compare for read measurement.
module tff_pulse_timer
  import tff_ctrl_pkg::*;
#(
  parameter int          CW      = 7,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          dn_load,
  input  logic [CW-1:0] dn_val,
  input  logic          dn_dec,
  input  logic          up_load,
  input  logic [CW-1:0] up_val,
  input  logic          up_inc,
  output logic [CW-1:0] up,
  output logic          dn_last,
  output logic          up_last
);
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic [CW-1:0] dn;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dn <= '0;
      up <= '0;
    end else begin
      if (dn_load)
        dn <= dn_val;
      else if (dn_dec && dn != '0)
        dn <= dn - 1'b1;
      if (up_load)
        up <= up_val;
      else if (up_inc)
        up <= CW'(sat_add(32'(up), 32'd1, CMAX));
    end
  end

  // "last" flags let the FSM leave on the final cycle rather than one late.
  assign dn_last = (dn <= CW'(1));
  assign up_last = (32'(up) == TIMEOUT - 1);

endmodule

// File: rtl/tff_bank_ctrl.sv
// Request sequencer for a bank of time-domain storage cells: turns write/read
// requests into one-hot WE/RE pulses and measures Q pulse width on reads.
module tff_bank_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int          NCELL       = 8,
  parameter int          AW          = 3,
  parameter int          CW          = 7,
  parameter int unsigned MAX_COUNT   = MAX_COUNT_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned GAP         = GAP_DEF,
  parameter int unsigned READ_OFFSET = 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wr,
  input  logic [AW-1:0]    req_addr,
  input  logic [CW-1:0]    req_data,
  output logic             rsp_valid,
  output logic [CW-1:0]    rsp_data,
  output logic             rsp_sat,
  output logic             rsp_err,
  output logic             busy,
  output logic [NCELL-1:0] cell_we,
  output logic [NCELL-1:0] cell_re,
  input  logic [NCELL-1:0] cell_q,
  input  logic [NCELL-1:0] cell_cout
);
  localparam int unsigned CMAX = (1 << CW) - 1;

  state_e           state, state_n;
  op_e              req_op;
  logic [AW-1:0]    addr_q;
  logic [NCELL-1:0] sel, req_sel;
  logic             accept, addr_ok, clamp, q_sel, cout_sel, cout_req;
  logic [CW-1:0]    len;
  logic [CW-1:0]    res_data, res_data_n;
  logic             res_sat, res_sat_n, res_err, res_err_n;
  logic             dn_load, dn_dec, up_load, up_inc, dn_last, up_last;
  logic [CW-1:0]    dn_val, up_val, up;

  // Address decode by comparison keeps out-of-range addresses from selecting anything.
  always_comb begin
    for (int i = 0; i < NCELL; i++) begin
      sel[i]     = (int'(addr_q) == i);
      req_sel[i] = (int'(req_addr) == i);
    end
  end

  assign addr_ok  = |req_sel;
  assign q_sel    = |(cell_q & sel);
  assign cout_sel = |(cell_cout & sel);
  assign cout_req = |(cell_cout & req_sel);
  assign req_op   = op_e'(req_wr);
  assign clamp    = 32'(req_data) > MAX_COUNT;
  assign len      = CW'(sat_add(32'(req_data), 32'd0, MAX_COUNT));
  assign accept   = (state == ST_IDLE) && req_valid && req_ready;

  always_comb begin
    state_n    = state;
    res_data_n = res_data;
    res_sat_n  = res_sat;
    res_err_n  = res_err;
    dn_load    = 1'b0;
    dn_val     = '0;
    dn_dec     = 1'b0;
    up_load    = 1'b0;
    up_val     = '0;
    up_inc     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          res_data_n = '0;
          res_sat_n  = 1'b0;
          res_err_n  = 1'b0;
          up_load    = 1'b1;
          if (!addr_ok) begin
            res_err_n = 1'b1;
            state_n   = ST_GAP;
          end else if (req_op == OP_WR) begin
            res_sat_n = clamp | cout_req;
            if (len == '0 || cout_req) begin
              state_n = ST_GAP;
            end else begin
              dn_load = 1'b1;
              dn_val  = len;
              state_n = ST_WRITE;
            end
          end else begin
            state_n = ST_READ_WAIT;
          end
        end
      end
      ST_WRITE: begin
        // up counts WE-high cycles, including the one that ends the pulse.
        up_inc = 1'b1;
        dn_dec = 1'b1;
        if (cout_sel || dn_last) begin
          res_data_n = up + 1'b1;
          res_sat_n  = res_sat | cout_sel;
          state_n    = ST_GAP;
        end
      end
      ST_READ_WAIT: begin
        if (q_sel) begin
          up_load = 1'b1;
          up_val  = CW'(1);
          state_n = ST_READ_MEAS;
        end else if (up_last) begin
          res_err_n  = 1'b1;
          res_data_n = '0;
          state_n    = ST_GAP;
        end else begin
          up_inc = 1'b1;
        end
      end
      ST_READ_MEAS: begin
        if (!q_sel) begin
          res_data_n = CW'(floor_sub(32'(up), READ_OFFSET));
          state_n    = ST_GAP;
        end else if (up_last) begin
          res_err_n  = 1'b1;
          res_data_n = CW'(CMAX);
          state_n    = ST_GAP;
        end else begin
          up_inc = 1'b1;
        end
      end
      ST_GAP: begin
        dn_dec = 1'b1;
        if (dn_last) state_n = ST_RESP;
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (state_n == ST_GAP && state != ST_GAP) begin
      dn_load = 1'b1;
      dn_val  = CW'(GAP);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      req_ready <= 1'b0;
      res_data  <= '0;
      res_sat   <= 1'b0;
      res_err   <= 1'b0;
      rsp_data  <= '0;
      rsp_sat   <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == ST_IDLE);
      if (accept) addr_q <= req_addr;
      res_data  <= res_data_n;
      res_sat   <= res_sat_n;
      res_err   <= res_err_n;
      if (state_n == ST_RESP) begin
        rsp_data <= res_data;
        rsp_sat  <= res_sat;
        rsp_err  <= res_err;
      end
    end
  end

  tff_pulse_timer #(
    .CW      (CW),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rstb    (rstb),
    .dn_load (dn_load),
    .dn_val  (dn_val),
    .dn_dec  (dn_dec),
    .up_load (up_load),
    .up_val  (up_val),
    .up_inc  (up_inc),
    .up      (up),
    .dn_last (dn_last),
    .up_last (up_last)
  );

  // Cell strobes decode straight from state so async reset clears them at once.
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);
  assign cell_we   = (state == ST_WRITE) ? sel : '0;
  assign cell_re   = (state == ST_READ_WAIT || state == ST_READ_MEAS) ? sel : '0;

endmodule

// File: doc/tff_bank_ctrl.md
Name: tff_bank_ctrl

Overview:
Sequencer for a bank of NCELL time-domain storage cells (tff instances). Converts digital write/read requests into timed per-cell WE/RE pulses. Writes accumulate N time units into a cell. Reads assert RE and measure the width of the cell's Q pulse, then return it as a digital count. Sits between the bus-side request interface and the cell array; exactly one cell operation is in flight at a time.

Parameters:
NCELL, 8, number of cells in the bank
AW, 3, address width (clog2 NCELL)
CW, 7, count/data width
MAX_COUNT, 59, cell capacity in time units; write length clamp
TIMEOUT, 127, read watchdog in clk cycles, both phases
GAP, 2, idle cycles with all WE/RE low between end of pulse and response
READ_OFFSET, 1, subtracted from measured Q-high cycles

Ports:
clk  in  1  system clock; one cell time unit = one clk cycle
rstb  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept request
req_wr  in  1  1=write (accumulate), 0=read
req_addr  in  AW  target cell
req_data  in  CW  write length in units (ignored on read)
rsp_valid  out  1  single-cycle response strobe
rsp_data  out  CW  write: units actually pulsed; read: measured count
rsp_sat  out  1  write clamped or cell carry seen
rsp_err  out  1  read watchdog expired
busy  out  1  high whenever FSM not IDLE
cell_we  out  NCELL  one-hot write enable to cells
cell_re  out  NCELL  one-hot read enable to cells
cell_q  in  NCELL  cell Q outputs
cell_cout  in  NCELL  cell carry/full flags

Behaviour:
- Reset (async, rstb=0): FSM=IDLE, all outputs 0 immediately, including cell_we/cell_re mid-pulse; req_ready rises on first clk edge after release.
- States: IDLE, WRITE, READ_WAIT, READ_MEAS, GAP, RESP.
- IDLE: req_ready=1. Accept on clk edge T with req_valid&req_ready; latch addr/data/op; req_ready=0 from T.
- Write: len = min(req_data, MAX_COUNT); sat=1 if clamped. If len==0 or cell_cout[addr]==1 at T: no pulse, go to GAP (sat=1 in cout case). Else cell_we[addr]=1 for cycles T+1..T+len. If cell_cout[addr] samples 1 during WRITE: drop WE next cycle, sat=1. rsp_data = cycles WE actually high.
- Read: cell_re[addr]=1 from T+1, held through READ_WAIT and READ_MEAS. READ_WAIT: wait for cell_q[addr]=1; if not seen within TIMEOUT cycles -> err=1, data=0, go to GAP. READ_MEAS: count cycles with q=1 (saturating at 2^CW-1); on q falling, drop RE and go to GAP; rsp_data = max(count-READ_OFFSET, 0). If q is high TIMEOUT cycles -> err=1, data=2^CW-1, drop RE.
- GAP: GAP cycles with all cell_we/cell_re low, then RESP.
- RESP: rsp_valid=1 for exactly one cycle with data/sat/err. No backpressure. Next cycle IDLE, req_ready=1. rsp_data/sat/err hold until the next RESP.
- Invariants: at most one bit of cell_we|cell_re high; never WE and RE simultaneously; req_addr >= NCELL -> no pulse, err=1, data=0.
- Write latency for len=N: rsp_valid at T+N+GAP+1.

Decomposition:
- Package tff_ctrl_pkg: state enum, op encoding (OP_RD/OP_WR), default MAX_COUNT/TIMEOUT constants, saturate helper function.
- One sub-module: tff_pulse_timer (loadable down-counter for WE length/GAP plus saturating up-counter with watchdog compare for read measure), instantiated once and shared by all states.

Test Plan:
- Reset, write addr 2 data 10 -> cell_we[2] high exactly cycles T+1..T+10, rsp_valid at T+13, rsp_data=10, sat=0.
- Write data 100 to empty cell -> WE high 59 cycles, rsp_data=59, sat=1; cout driven at cycle 40 instead -> WE drops, rsp_data=40, sat=1.
- Read with model cell returning Q high 11 cycles -> rsp_data=10, err=0; RE drops the cycle after Q falls.
- Read with Q never rising -> rsp_valid after 127+GAP cycles, err=1, data=0; Q stuck high -> err=1, data=127.
- Back-to-back requests with req_valid held -> second accepted only in the cycle after RESP; one-hot/WE-RE exclusion asserted throughout.
- rstb pulsed low mid-WRITE -> cell_we=0 asynchronously, busy=0, no rsp_valid; next request is served normally.
